// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment scanner: one digit owns the shared segment bus per slot.
// Define SCAN_GUARD_EN to insert GUARD_CYC all-off cycles between digits.
module display_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_W      = 7,
  parameter int DIV        = 50000,
  parameter int GUARD_CYC  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_DIGITS*SEG_W-1:0]     seg_in,
  input  logic [NUM_DIGITS-1:0]           dp_in,
  output logic [SEG_W-1:0]                seg_out,
  output logic                            dp_out,
  output logic [NUM_DIGITS-1:0]           an_out,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                            frame_tick
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [SEG_W-1:0]      seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  tick_q;

  logic                  drive;
  logic                  slot_end;
  logic                  idx_wrap;
  logic [SEG_W-1:0]      sel_seg;
  logic                  sel_dp;
  logic [NUM_DIGITS-1:0] sel_an;

  // Unreachable index codes fall through to an all-off pattern.
  always_comb begin
    sel_seg = '1;
    sel_dp  = 1'b1;
    sel_an  = '1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_q == IW'(d)) begin
        sel_seg   = seg_in[d*SEG_W +: SEG_W];
        sel_dp    = dp_in[d];
        sel_an[d] = 1'b0;
      end
    end
  end

  assign slot_end = drive && (cnt_q == CNT_LAST);
  assign idx_wrap = (idx_q == IDX_LAST);

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (drive) begin
      cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    end
    if (slot_end) begin
      idx_d = idx_wrap ? '0 : idx_q + IW'(1);
    end
  end

`ifdef SCAN_GUARD_EN

  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYC - 1);

  typedef enum logic {
    S_DRIVE = 1'b0,
    S_GUARD = 1'b1
  } state_t;

  state_t        state_q;
  logic [GW-1:0] gcnt_q;

  assign drive = enable && (state_q == S_DRIVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_DRIVE;
      gcnt_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= '1;
      dp_q    <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      tick_q <= slot_end && idx_wrap;
      an_q   <= drive ? sel_an  : '1;
      seg_q  <= drive ? sel_seg : '1;
      dp_q   <= drive ? sel_dp  : 1'b1;
      unique case (state_q)
        S_DRIVE: begin
          if (slot_end) begin
            state_q <= S_GUARD;
            gcnt_q  <= '0;
          end
        end
        S_GUARD: begin
          if (enable) begin
            if (gcnt_q == G_LAST) begin
              state_q <= S_DRIVE;
              gcnt_q  <= '0;
            end else begin
              gcnt_q <= gcnt_q + GW'(1);
            end
          end
        end
        default: state_q <= S_DRIVE;
      endcase
    end
  end

`else

  assign drive = enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      seg_q  <= '1;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      tick_q <= slot_end && idx_wrap;
      an_q   <= drive ? sel_an  : '1;
      seg_q  <= drive ? sel_seg : '1;
      dp_q   <= drive ? sel_dp  : 1'b1;
    end
  end

`endif

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

  a_an_onehot: assert property (
    @(posedge clk) disable iff (reset) $onehot0(~an_out)
  );

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: NUM_DIGITS=4, DIV=4.
// Build with SCAN_GUARD_EN to exercise the guard-interval variant instead.
module tb_display_scan_mux;

  localparam int ND = 4;
  localparam int SW = 7;
  localparam int DV = 4;
  localparam int GC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [ND*SW-1:0] seg_in;
  logic [ND-1:0] dp_in;
  logic [SW-1:0] seg_out;
  logic          dp_out;
  logic [ND-1:0] an_out;
  logic [1:0]    digit_idx;
  logic          frame_tick;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [4];
  logic [3:0] an_tab  [4];

  always #5 clk = ~clk;

  display_scan_mux #(
    .NUM_DIGITS(ND),
    .SEG_W     (SW),
    .DIV       (DV),
    .GUARD_CYC (GC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .seg_in    (seg_in),
    .dp_in     (dp_in),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .an_out    (an_out),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seg();
    seg_in = {seg_tab[3], seg_tab[2], seg_tab[1], seg_tab[0]};
  endtask

  task automatic chk_blank(input string tag, input int idx);
    chk({tag, ".an"},   32'(an_out),     32'hF);
    chk({tag, ".seg"},  32'(seg_out),    32'h7F);
    chk({tag, ".dp"},   32'(dp_out),     32'h1);
    chk({tag, ".idx"},  32'(digit_idx),  32'(idx));
    chk({tag, ".tick"}, 32'(frame_tick), 32'h0);
  endtask

  // After edge k (k=1 is the first edge after release) the pins show
  // digit (k-1)/4 and the index register already holds k/4.
  task automatic run_scan(input string tag, input int k0, input int k1);
    int d;
    for (int k = k0; k <= k1; k++) begin
      tick();
      d = ((k - 1) / 4) % 4;
      chk({tag, ".an"},   32'(an_out),     32'(an_tab[d]));
      chk({tag, ".seg"},  32'(seg_out),    32'(seg_tab[d]));
      chk({tag, ".dp"},   32'(dp_out),     32'(dp_in[d]));
      chk({tag, ".idx"},  32'(digit_idx),  32'((k / 4) % 4));
      chk({tag, ".tick"}, 32'(frame_tick), 32'((k % 16) == 0));
    end
  endtask

  // Guard build: 4 drive cycles then 2 blank cycles per digit.
  task automatic run_guard(input string tag, input int k0, input int k1);
    int d;
    int p;
    for (int k = k0; k <= k1; k++) begin
      tick();
      d = ((k - 1) / 6) % 4;
      p = (k - 1) % 6;
      if (p < 4) begin
        chk({tag, ".an"},  32'(an_out),  32'(an_tab[d]));
        chk({tag, ".seg"}, 32'(seg_out), 32'(seg_tab[d]));
      end else begin
        chk({tag, ".an"},  32'(an_out),  32'hF);
        chk({tag, ".seg"}, 32'(seg_out), 32'h7F);
      end
      chk({tag, ".idx"},  32'(digit_idx),  32'(((k + 2) / 6) % 4));
      chk({tag, ".tick"}, 32'(frame_tick), 32'((k % 24) == 22));
    end
  endtask

  initial begin
    an_tab[0]  = 4'b1110;
    an_tab[1]  = 4'b1101;
    an_tab[2]  = 4'b1011;
    an_tab[3]  = 4'b0111;
    seg_tab[0] = 7'h40;
    seg_tab[1] = 7'h30;
    seg_tab[2] = 7'h24;
    seg_tab[3] = 7'h79;
    load_seg();
    dp_in  = 4'b0101;
    enable = 1'b1;
    reset  = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk_blank("reset", 0);
    end
    reset = 1'b0;

`ifdef SCAN_GUARD_EN
    run_guard("guard", 1, 30);
`else
    run_scan("scan", 1, 42);

    // idx=2 with two cycles of its slot still to go
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_blank("hold", 2);
    end
    enable = 1'b1;
    run_scan("resume", 43, 53);

    // idx=1 mid-slot: new digit-1 pattern shows next cycle
    seg_tab[1] = 7'h12;
    load_seg();
    run_scan("live", 54, 61);

    // idx=3 mid-slot
    reset = 1'b1;
    tick();
    chk_blank("midrst", 0);
    reset = 1'b0;
    run_scan("rescan", 1, 8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
